// File: rtl/jtflane_pcm_arb.sv
// jtflane_pcm_arb: four one-byte tagged PCM ROM caches sharing one sample-ROM port, misses served round-robin
// Define JTFLANE_PCM_ARB_STATS_EN to add saturating miss_cnt/hit_cnt outputs.
module jtflane_pcm_arb #(
  parameter int AW = 19,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic [3:0]      ch_cs,
  input  logic [4*AW-1:0] ch_addr,
  output logic [4*DW-1:0] ch_dout,
  output logic [3:0]      ch_ok,
  output logic            rom_cs,
  output logic [AW+1:0]   rom_addr,
  input  logic [DW-1:0]   rom_data,
  input  logic            rom_ok
`ifdef JTFLANE_PCM_ARB_STATS_EN
  ,
  output logic [15:0]     miss_cnt,
  output logic [15:0]     hit_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t st, st_nx;
  logic [AW-1:0] addr [4];
  logic [AW-1:0] tag [4];
  logic [DW-1:0] data [4];
  logic [3:0] valid, hit, pend;
  logic [1:0] last, gnt, sel;
  logic discard, done;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    assign addr[i] = ch_addr[i*AW +: AW];
    assign hit[i] = valid[i] && tag[i] == addr[i];
    assign ch_ok[i] = ch_cs[i] && hit[i];
    assign pend[i] = ch_cs[i] && !hit[i];
    assign ch_dout[i*DW +: DW] = data[i];
  end

  // scan from last+1 upward; the nearest pending channel is assigned last
  always_comb begin
    gnt = last;
    for (int k = 4; k >= 1; k--)
      if (pend[last + 2'(k)]) gnt = last + 2'(k);
  end

  always_comb st_nx = st == IDLE ? (|pend ? REQ : IDLE) : st == REQ ? WAIT : rom_ok ? IDLE : WAIT;

  assign rom_cs = st != IDLE;
  assign done = st == WAIT && rom_ok;
  assign sel = rom_addr[AW +: 2];

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st <= IDLE;
      last <= 2'd3;
      rom_addr <= '0;
      valid <= '0;
      discard <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        tag[k] <= '0;
        data[k] <= '0;
      end
    end else begin
      st <= st_nx;
      if (st == IDLE && |pend) begin
        rom_addr <= {gnt, addr[gnt]};
        discard <= 1'b0;
      end
      if (flush && rom_cs) discard <= 1'b1;
      if (done) last <= sel;
      if (done && !flush && !discard) begin
        tag[sel] <= rom_addr[AW-1:0];
        data[sel] <= rom_data;
        valid[sel] <= 1'b1;
      end
      if (flush) valid <= '0;
    end

`ifdef JTFLANE_PCM_ARB_STATS_EN
  logic [AW-1:0] prev [4];
  logic new_hit;

  always_comb begin
    new_hit = 1'b0;
    for (int k = 0; k < 4; k++) new_hit = new_hit | (ch_ok[k] && addr[k] != prev[k]);
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      miss_cnt <= '0;
      hit_cnt <= '0;
      for (int k = 0; k < 4; k++) prev[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) prev[k] <= addr[k];
      if (done && ~&miss_cnt) miss_cnt <= miss_cnt + 16'd1;
      if (new_hit && ~&hit_cnt) hit_cnt <= hit_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_jtflane_pcm_arb.sv
// tb_jtflane_pcm_arb: directed scenarios plus randomized traffic against a transaction-level cache/arbiter model
module tb_jtflane_pcm_arb;
  localparam int AW = 19, DW = 8;
  logic clk = 0, rstn = 0, flush = 0;
  logic [3:0] ch_cs = '0;
  logic [4*AW-1:0] ch_addr = '0;
  logic [4*DW-1:0] ch_dout;
  logic [3:0] ch_ok;
  logic rom_cs, rom_ok = 0;
  logic [AW+1:0] rom_addr;
  logic [DW-1:0] rom_data;
  int n_tests = 0, n_fail = 0;
  bit tie_ok = 0, rnd_dly = 0;
  int delay = 1;

  always #5 clk = ~clk;

  jtflane_pcm_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .ch_cs(ch_cs), .ch_addr(ch_addr),
    .ch_dout(ch_dout), .ch_ok(ch_ok), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok)
  );

  function automatic logic [7:0] rom_fn(input logic [AW+1:0] a);
    return a[7:0] ^ a[15:8] ^ {3'b0, a[20:16]} ^ 8'h4A;
  endfunction

  function automatic logic [AW-1:0] ga(input int i);
    return ch_addr[i*AW +: AW];
  endfunction

  assign rom_data = rom_fn(rom_addr);

  // ROM responder: answers a number of cycles after the request appears
  int wcnt = 0, cur_dly = 1;
  always @(negedge clk) begin
    if (rom_cs) begin
      if (wcnt == 0) cur_dly = rnd_dly ? int'($urandom_range(1, 5)) : delay;
      wcnt++;
    end else wcnt = 0;
    rom_ok = tie_ok || (rom_cs && wcnt >= cur_dly);
  end

  // reference model: one outstanding fetch, first answer after the request cycle completes it
  bit m_busy = 0, m_disc = 0;
  int m_age = 0;
  logic [1:0] m_ch = 0, m_last = 3;
  logic [AW-1:0] m_addr = 0;
  bit m_valid [4];
  logic [AW-1:0] m_tag [4];
  logic [7:0] m_data [4];
  always @(posedge clk or negedge rstn) begin
    bit found;
    int c;
    if (!rstn) begin
      m_busy = 0; m_disc = 0; m_age = 0; m_last = 3;
      for (int i = 0; i < 4; i++) m_valid[i] = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        c = (int'(m_last) + k) % 4;
        if (!found && ch_cs[c] && !(m_valid[c] && m_tag[c] == ga(c))) begin
          found = 1; m_busy = 1; m_age = 0; m_disc = 0; m_ch = 2'(c); m_addr = ga(c);
        end
      end
      if (flush) for (int i = 0; i < 4; i++) m_valid[i] = 0;
    end else begin
      if (flush) m_disc = 1;
      if (m_age >= 1 && rom_ok) begin
        m_busy = 0;
        m_last = m_ch;
        if (!m_disc) begin
          m_valid[m_ch] = 1; m_tag[m_ch] = m_addr; m_data[m_ch] = rom_fn({m_ch, m_addr});
        end
      end
      m_age++;
      if (flush) for (int i = 0; i < 4; i++) m_valid[i] = 0;
    end
  end

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_a(input int i, input logic [AW-1:0] v);
    ch_addr[i*AW +: AW] = v;
  endtask

  task automatic do_reset;
    rstn = 0; ch_cs = 0; ch_addr = '0; flush = 0; tie_ok = 0; rnd_dly = 0; delay = 1;
    adv(2);
    rstn = 1;
    adv(1);
  endtask

  task automatic wait_cs(input bit lvl, input string nm);
    int t = 0;
    while (rom_cs !== lvl && t < 40) begin adv(1); t++; end
    n_tests++;
    if (rom_cs !== lvl) begin n_fail++; $display("FAIL %s: rom_cs=%b, wanted %b within 40 cycles", nm, rom_cs, lvl); end
  endtask

  task automatic test_reset;
    adv(2);
    n_tests++; if (rom_cs !== 1'b0) begin n_fail++; $display("FAIL reset_rom_cs: got %b want 0", rom_cs); end
    n_tests++; if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
    n_tests++; if (ch_ok !== 4'b0) begin n_fail++; $display("FAIL reset_ch_ok: got %b want 0", ch_ok); end
    n_tests++; if (ch_dout !== '0) begin n_fail++; $display("FAIL reset_ch_dout: got %h want 0", ch_dout); end
    rstn = 1;
    adv(1);
  endtask

  task automatic test_miss_hit;
    tie_ok = 1; ch_cs = 4'b0001; set_a(0, 19'h10);
    #1;
    n_tests++; if (ch_ok !== 4'b0) begin n_fail++; $display("FAIL miss_ok0: got %b want 0000", ch_ok); end
    adv(1);
    n_tests++; if (rom_cs !== 1'b1 || rom_addr !== 21'h000010) begin n_fail++; $display("FAIL miss_req: rom_cs=%b rom_addr=%h want 1/000010", rom_cs, rom_addr); end
    adv(1);
    n_tests++; if (ch_ok[0] !== 1'b0) begin n_fail++; $display("FAIL miss_ok2: got %b want 0", ch_ok[0]); end
    adv(1);
    n_tests++; if (ch_ok[0] !== 1'b1 || ch_dout[7:0] !== 8'h5A) begin n_fail++; $display("FAIL miss_ok3: ok=%b dout=%h want 1/5a", ch_ok[0], ch_dout[7:0]); end
    ch_cs = 0;
    adv(1);
    n_tests++; if (rom_cs !== 1'b0 || ch_ok !== 4'b0) begin n_fail++; $display("FAIL idle_after: rom_cs=%b ok=%b want 0/0000", rom_cs, ch_ok); end
    ch_cs = 4'b0001;
    #1;
    n_tests++; if (ch_ok !== 4'b0001) begin n_fail++; $display("FAIL hit0: got %b want 0001", ch_ok); end
    adv(1);
    n_tests++; if (rom_cs !== 1'b0 || ch_ok !== 4'b0001) begin n_fail++; $display("FAIL hit_nobus: rom_cs=%b ok=%b want 0/0001", rom_cs, ch_ok); end
    tie_ok = 0; ch_cs = 0;
    adv(2);
  endtask

  task automatic test_round_robin;
    logic [AW-1:0] a [4];
    do_reset();
    delay = 5;
    for (int i = 0; i < 4; i++) begin a[i] = 19'h100 + 19'(i) * 19'h1111; set_a(i, a[i]); end
    ch_cs = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_cs(1, "rr_start");
      n_tests++; if (rom_addr !== {2'(k), a[k]}) begin n_fail++; $display("FAIL rr_addr%0d: got %h want %h", k, rom_addr, {2'(k), a[k]}); end
      n_tests++; if (ch_ok !== 4'((1 << k) - 1)) begin n_fail++; $display("FAIL rr_ok_pre%0d: got %b want %b", k, ch_ok, 4'((1 << k) - 1)); end
      wait_cs(0, "rr_end");
      n_tests++; if (ch_ok !== 4'((1 << (k + 1)) - 1)) begin n_fail++; $display("FAIL rr_ok_post%0d: got %b want %b", k, ch_ok, 4'((1 << (k + 1)) - 1)); end
    end
  endtask

  task automatic test_addr_move;
    int t = 0;
    do_reset();
    delay = 4; ch_cs = 4'b0100; set_a(2, 19'h40000);
    wait_cs(1, "mv_start");
    n_tests++; if (rom_addr !== {2'd2, 19'h40000}) begin n_fail++; $display("FAIL mv_addr: got %h want %h", rom_addr, {2'd2, 19'h40000}); end
    adv(1);
    set_a(2, 19'h40001);
    #1;
    while (rom_cs && t < 20) begin
      n_tests++; if (rom_addr !== {2'd2, 19'h40000} || ch_ok[2] !== 1'b0) begin n_fail++; $display("FAIL mv_hold: addr=%h ok=%b want %h/0", rom_addr, ch_ok[2], {2'd2, 19'h40000}); end
      adv(1); t++;
    end
    n_tests++; if (ch_ok[2] !== 1'b0) begin n_fail++; $display("FAIL mv_stale: ok=%b want 0", ch_ok[2]); end
    wait_cs(1, "mv_refetch");
    n_tests++; if (rom_addr !== {2'd2, 19'h40001}) begin n_fail++; $display("FAIL mv_addr2: got %h want %h", rom_addr, {2'd2, 19'h40001}); end
    wait_cs(0, "mv_done");
    n_tests++; if (ch_ok[2] !== 1'b1 || ch_dout[23:16] !== rom_fn({2'd2, 19'h40001})) begin n_fail++; $display("FAIL mv_final: ok=%b dout=%h want 1/%h", ch_ok[2], ch_dout[23:16], rom_fn({2'd2, 19'h40001})); end
  endtask

  task automatic test_flush;
    int t = 0;
    do_reset();
    delay = 3; ch_cs = 4'b0001; set_a(0, 19'h1234);
    wait_cs(1, "fl_a");
    wait_cs(0, "fl_a_done");
    n_tests++; if (ch_ok !== 4'b0001) begin n_fail++; $display("FAIL fl_a_ok: got %b want 0001", ch_ok); end
    set_a(1, 19'h5678); ch_cs = 4'b0011;
    wait_cs(1, "fl_b");
    while (!(rom_ok && rom_cs) && t < 20) begin adv(1); t++; end
    n_tests++; if (!(rom_ok && rom_cs)) begin n_fail++; $display("FAIL fl_wait_ok: rom_ok=%b rom_cs=%b want 1/1", rom_ok, rom_cs); end
    flush = 1;
    adv(1);
    flush = 0;
    #1;
    n_tests++; if (ch_ok !== 4'b0 || rom_cs !== 1'b0) begin n_fail++; $display("FAIL fl_clear: ok=%b rom_cs=%b want 0000/0", ch_ok, rom_cs); end
    wait_cs(1, "fl_re_a");
    n_tests++; if (rom_addr !== {2'd0, 19'h1234}) begin n_fail++; $display("FAIL fl_re_a_addr: got %h want %h", rom_addr, {2'd0, 19'h1234}); end
    wait_cs(0, "fl_re_a_done");
    wait_cs(1, "fl_re_b");
    n_tests++; if (rom_addr !== {2'd1, 19'h5678}) begin n_fail++; $display("FAIL fl_re_b_addr: got %h want %h", rom_addr, {2'd1, 19'h5678}); end
    wait_cs(0, "fl_re_b_done");
    n_tests++; if (ch_ok !== 4'b0011) begin n_fail++; $display("FAIL fl_final: got %b want 0011", ch_ok); end
  endtask

  task automatic test_async_reset;
    do_reset();
    delay = 8; set_a(0, 19'h0AAAA); set_a(1, 19'h0BBBB); ch_cs = 4'b0011;
    wait_cs(1, "ar_a");
    wait_cs(0, "ar_a_done");
    wait_cs(1, "ar_b");
    n_tests++; if (rom_addr !== {2'd1, 19'h0BBBB}) begin n_fail++; $display("FAIL ar_b_addr: got %h want %h", rom_addr, {2'd1, 19'h0BBBB}); end
    adv(2);
    rstn = 0;
    #1;
    n_tests++; if (rom_cs !== 1'b0 || ch_ok !== 4'b0) begin n_fail++; $display("FAIL ar_abort: rom_cs=%b ok=%b want 0/0000", rom_cs, ch_ok); end
    adv(1);
    rstn = 1;
    wait_cs(1, "ar_first");
    n_tests++; if (rom_addr !== {2'd0, 19'h0AAAA}) begin n_fail++; $display("FAIL ar_first_addr: got %h want %h", rom_addr, {2'd0, 19'h0AAAA}); end
  endtask

  task automatic test_random;
    logic [3:0] exp_ok;
    logic [4*DW-1:0] exp_dout, mask;
    do_reset();
    rnd_dly = 1;
    for (int i = 0; i < 4; i++) set_a(i, 19'(i) << 16);
    for (int n = 0; n < 600; n++) begin
      adv(1);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) set_a(i, (19'(i) << 16) | 19'($urandom_range(0, 3)));
        ch_cs[i] = $urandom_range(0, 3) != 0;
      end
      flush = $urandom_range(0, 49) == 0;
      #1;
      exp_ok = '0; exp_dout = '0; mask = '0;
      for (int i = 0; i < 4; i++) begin
        exp_ok[i] = ch_cs[i] && m_valid[i] && m_tag[i] == ga(i);
        if (m_valid[i]) begin exp_dout[i*DW +: DW] = m_data[i]; mask[i*DW +: DW] = '1; end
      end
      n_tests++; if (ch_ok !== exp_ok) begin n_fail++; $display("FAIL rnd_ok@%0d: got %b want %b", n, ch_ok, exp_ok); end
      n_tests++; if (rom_cs !== m_busy) begin n_fail++; $display("FAIL rnd_cs@%0d: got %b want %b", n, rom_cs, m_busy); end
      if (m_busy) begin
        n_tests++; if (rom_addr !== {m_ch, m_addr}) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", n, rom_addr, {m_ch, m_addr}); end
      end
      n_tests++; if ((ch_dout & mask) !== exp_dout) begin n_fail++; $display("FAIL rnd_dout@%0d: got %h want %h", n, ch_dout & mask, exp_dout); end
    end
    flush = 0; rnd_dly = 0;
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_round_robin();
    test_addr_move();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
